// File: rtl/uart_tx.sv
// 8-N-1 serial transmitter draining a show-ahead FIFO; back-to-back frames with no idle gap.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned ClocksPerBit = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_read_data_i,
  output logic       fifo_read_enable_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned TimerW = (ClocksPerBit > 2) ? $clog2(ClocksPerBit) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(ClocksPerBit - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [TimerW-1:0]   bit_timer_q, bit_timer_d;
  logic [2:0]          bit_index_q, bit_index_d;
  logic                tx_q, tx_d;
  logic                bit_last;
  logic                pop;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign bit_last = (bit_timer_q == TimerMax);

  // Pop is combinational so the head entry is captured in the same cycle it is removed.
  assign pop = !reset_i && !fifo_empty_i &&
               ((state_q == StIdle) || ((state_q == StStop) && bit_last));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_index_d = bit_index_q;
    bit_timer_d = bit_last ? '0 : bit_timer_q + 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        bit_timer_d = '0;
      end
      StStart: begin
        if (bit_last) begin
          state_d     = StData;
          bit_index_d = '0;
        end
      end
      StData: begin
        if (bit_last) begin
          if (bit_index_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_index_d = bit_index_q + 3'd1;
            shift_d     = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_last) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A pop from IDLE or the last stop cycle starts the next frame immediately.
    if (pop) begin
      state_d     = StStart;
      shift_d     = fifo_read_data_i;
      bit_timer_d = '0;
      bit_index_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^fifo_read_data_i;
`endif
    end
  end

  // Line level is registered from the next state so tx lines up with the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_timer_q <= '0;
      bit_index_q <= '0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_timer_q <= bit_timer_d;
      bit_index_q <= bit_index_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign fifo_read_enable_o = pop;
  assign tx_o               = tx_q;
  assign busy_o             = (state_q != StIdle);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (!(fifo_read_enable_o && fifo_empty_i));
    if (!reset_i && state_q == StIdle) begin
      assert (tx_q == 1'b1);
    end
  end
`endif

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains bytes from an upstream show-ahead FIFO and shifts them out as 8-N-1 asynchronous serial frames. It sits directly downstream of the transmit FIFO: it watches the FIFO's `empty` flag, samples the FIFO's combinational `read_data`, and pulses the FIFO's `read_enable` to pop. Its output drives the board UART TX pin.

## Interface
- `clocks_per_bit`, default 4, clock cycles per serial bit; legal values are ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  upstream FIFO empty flag.
- `fifo_read_data`  in  8  upstream FIFO head entry; valid whenever `fifo_empty`=0.
- `fifo_read_enable`  out  1  pop strobe to upstream FIFO.
- `tx`  out  1  serial line output; idle high.
- `busy`  out  1  high while a frame is in progress.

## Operation
- States:
  - IDLE
  - START (tx=0)
  - DATA (tx=shift[0], LSB first, 8 bits)
  - PARITY (only when the macro is defined)
  - STOP (tx=1)
- `bit_timer` has width clog2(`clocks_per_bit`). It counts 0..`clocks_per_bit`-1 inside each bit, then wraps to 0 and the state or bit advances.
- `bit_index` is 3 bits and counts DATA bits 0..7. DATA exits after bit 7's final cycle.
- Pop condition:
  - `fifo_read_enable` = !`reset` && !`fifo_empty` && (state==IDLE || (state==STOP && `bit_timer`==`clocks_per_bit`-1)).
  - The output is combinational, so the pop occurs in the same cycle that `fifo_read_data` is captured.
- On a pop:
  - `fifo_read_data` is loaded into the shift register.
  - `bit_timer` and `bit_index` are cleared.
  - The next state is START.
- STOP final cycle with the FIFO empty: the next state is IDLE.
- STOP final cycle with the FIFO non-empty: the next state is START directly, so back-to-back frames have no idle gap.
- `busy` = (state != IDLE).
- `fifo_read_enable` is never asserted when `fifo_empty`=1. The block never relies on the FIFO ignoring an illegal pop.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `fifo_read_enable`=0.
  - State is IDLE; shift register, `bit_timer` and `bit_index` are 0.
- `tx` is registered.
- Latency:
  - The pop occurs in cycle N, with the FIFO non-empty and the block IDLE.
  - `tx` falls and `busy` rises in cycle N+1.
- Frame length: 10×`clocks_per_bit` cycles, or 11× with parity.
- Each bit holds `tx` stable for exactly `clocks_per_bit` cycles.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle.
- `fifo_empty` deasserting mid-frame has no effect until the STOP final cycle.
- Reset mid-frame:
  - The next cycle `tx`=1 and the block is IDLE.
  - The partially sent byte is dropped; it was already popped.
  - No pop occurs during the reset cycle.
- Reset asserted with the FIFO non-empty: no pop while `reset`=1. The first pop occurs in the first cycle after reset deasserts.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 data bits (even parity) for `clocks_per_bit` cycles.
  - The frame is 11 bits.
- Undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.
  - The frame is 10 bits.

## Test plan
All scenarios use `clocks_per_bit`=4 unless stated.

- Single byte, no parity:
  - Stimulus: push 0xA5 into an empty FIFO.
  - Exactly one `fifo_read_enable` pulse.
  - `tx`, in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` is high for exactly 40 cycles, then IDLE with `tx`=1.
- Back-to-back:
  - Stimulus: preload 0x00, 0xFF, 0x3C.
  - Three pops, each on a STOP final cycle (the first from IDLE).
  - Total 120 cycles with `busy` continuously high; no `tx` idle gap between frames.
- Empty FIFO:
  - Stimulus: `fifo_empty`=1 held for 100 cycles.
  - `fifo_read_enable` stays 0, `tx` stays 1, `busy` stays 0.
- Reset mid-frame:
  - Stimulus: assert `reset` during DATA bit 3 of 0x55.
  - Next cycle `tx`=1 and `busy`=0.
  - After release with 0x12 queued: a clean 0x12 frame; 0x55 is never resent.
- Parity (`UART_TX_PARITY_EN` defined):
  - 0x07 gives a parity bit of 1; 0x03 gives 0.
  - Frames are 44 cycles.
- Minimum divisor: with `clocks_per_bit`=2, 0xA5 gives the same bit pattern in 2-cycle bits, 20 cycles total.
